adder_tree_feeder: RTL and testbench
====================================

Name: adder_tree_feeder

Overview:
- Producer end of the adder tree's packed input bus.
- Accepts a stream of signed scalar elements over a valid/ready handshake, packs NUM consecutive elements into one vector, and emits the vector over a second valid/ready handshake.
- Sits directly upstream of the adder-tree reduction. Its output bus width and lane ordering match the tree's packed input exactly.
- Sustains one element per cycle when downstream is ready.

Parameters:
- INPUT_DATA_WIDTH, 16, bit width of one signed element (lane).
- NUM, 4, elements per output vector. Legal range 1..256.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- in_data  input  INPUT_DATA_WIDTH  signed element.
- in_valid  input  1  in_data valid.
- in_ready  output  1  block can accept in_data this cycle.
- out_data  output  INPUT_DATA_WIDTH*NUM  packed vector; lane k at bits [INPUT_DATA_WIDTH*(k+1)-1 : INPUT_DATA_WIDTH*k].
- out_valid  output  1  out_data holds a complete vector.
- out_ready  input  1  downstream accepts out_data this cycle.
- vec_count  output  16  wrapping count of vectors handed off (out_valid & out_ready).

Behaviour:
- Clock and reset: one clock (clk). Reset rst_n is synchronous and active-low.
- Reset values: out_valid=0, out_data=0, vec_count=0, lane index idx=0, pack register=0. in_ready is combinational and therefore reads 1 while reset is held.
- Storage: pack register holds lanes 0..NUM-2; output register holds the full vector. idx counts 0..NUM-1 and its width is clog2(NUM), minimum 1.
- Accept: an element is accepted when in_valid & in_ready.
  - Accepted element fills lane idx, and the arrival order maps to lanes 0,1,2,...
- in_ready = (idx != NUM-1) | !out_valid | out_ready.
  - Non-final lanes are never back-pressured.
  - The final lane is stalled only while the output register is occupied and not draining.
- Accept with idx < NUM-1: write pack lane idx, then idx <= idx+1.
- Accept with idx == NUM-1:
  - out_data <= {in_data, pack lanes NUM-2..0}, out_valid <= 1, idx <= 0, pack register <= 0.
  - Latency: the vector is visible on the cycle after the final element is accepted.
- Output handshake:
  - out_valid & out_ready with no simultaneous load: out_valid <= 0, and out_data keeps its value.
  - Handoff and load in the same cycle: the new vector is loaded and out_valid stays 1 (back-to-back vectors, no bubble).
  - Every handoff: vec_count <= vec_count+1, wrapping 0xFFFF -> 0.
- Stability: out_data and out_valid do not change while out_valid=1 & out_ready=0.
- Data: lanes are copied bit-exact, with no arithmetic, extension or saturation. Sign interpretation belongs to the consumer.
- NUM==1: there is no pack register, idx stays 0, and every accepted element loads the output register directly.
- Reset mid-vector: partially packed lanes and any pending output vector are discarded. Nothing is emitted after reset until NUM new elements arrive.
- in_valid without in_ready: nothing changes. Upstream holds its data, as the handshake requires.

Optional Feature:
- Macro: ADDER_TREE_FEEDER_FLUSH_EN.
- Defined:
  - Adds input port in_last (1 bit), sampled with the in_data handshake.
  - An accepted element with in_last=1 and idx < NUM-1 is written to lane idx, and the vector is emitted immediately.
  - Lanes idx+1..NUM-1 of that vector are zero. idx resets to 0.
  - For the in_ready computation, such an element counts as final, so in_ready uses (idx==NUM-1 | in_last) in place of (idx==NUM-1).
  - in_last on lane NUM-1 behaves as a normal full vector.
- Not defined: in_last does not exist, and vectors are emitted only after NUM elements.

Test Plan:
- Reset, then stream 1,2,3,4 with out_ready=1 (NUM=4, W=16) -> out_data=0x0004_0003_0002_0001, out_valid=1 one cycle after element 4, vec_count=1.
- Continuous 8-element stream 1..8 with out_ready=1 -> two vectors (..0004..0001 then ..0008..0005), in_ready held at 1 throughout, no bubble between vectors.
- out_ready=0 while vector A is held and elements 5,6,7,8 are offered:
  - 5, 6, 7 are accepted; in_ready=0 while 8 is offered; out_data stays A.
  - Raising out_ready -> A handed off and 8 accepted in the same cycle; vector B appears next cycle.
- Negative values -1,-32768,32767,0 -> out_data=0x0000_7FFF_8000_FFFF, bit-exact.
- Pulse rst_n=0 after 2 of 4 elements, then send 9,10,11,12 -> single vector 0x000C_000B_000A_0009, vec_count=1, no stale lanes.
- With ADDER_TREE_FEEDER_FLUSH_EN: send 5, then 6 with in_last=1 -> out_data=0x0000_0000_0006_0005. The next vector starts at lane 0.

Source files
------------

// File: rtl/adder_tree_feeder.sv
// Packs NUM consecutive signed elements into one vector for the adder tree input bus.
// Optional early-flush input in_last is enabled by defining ADDER_TREE_FEEDER_FLUSH_EN.
module adder_tree_feeder #(
    parameter int INPUT_DATA_WIDTH = 16,
    parameter int NUM              = 4
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [INPUT_DATA_WIDTH-1:0]       in_data,
    input  logic                              in_valid,
`ifdef ADDER_TREE_FEEDER_FLUSH_EN
    input  logic                              in_last,
`endif
    output logic                              in_ready,
    output logic [INPUT_DATA_WIDTH*NUM-1:0]   out_data,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [15:0]                       vec_count
);

    localparam int W     = INPUT_DATA_WIDTH;
    localparam int IDX_W = (NUM > 1) ? $clog2(NUM) : 1;

    logic [IDX_W-1:0] idx_r;
    logic [W*NUM-1:0] pack_ext_s;
    logic [W*NUM-1:0] next_vec_s;
    logic             last_lane_s;
    logic             final_s;
    logic             accept_s;
    logic             load_s;
    logic             handoff_s;

    assign last_lane_s = (idx_r == IDX_W'(NUM - 1));

`ifdef ADDER_TREE_FEEDER_FLUSH_EN
    assign final_s = last_lane_s | in_last;
`else
    assign final_s = last_lane_s;
`endif

    // Only the element that completes a vector can be stalled by a full, non-draining output
    assign in_ready  = ~final_s | ~out_valid | out_ready;
    assign accept_s  = in_valid & in_ready;
    assign load_s    = accept_s & final_s;
    assign handoff_s = out_valid & out_ready;

    // Outgoing vector: packed lanes below idx, the arriving element at idx, zeros above
    always_comb begin
        next_vec_s = {(W*NUM){1'b0}};
        for (int k = 0; k < NUM; k++) begin
            next_vec_s[k*W +: W] = (idx_r == IDX_W'(k)) ? in_data : pack_ext_s[k*W +: W];
        end
    end

    if (NUM > 1) begin : g_pack
        logic [W*(NUM-1)-1:0] pack_r;

        assign pack_ext_s = {{W{1'b0}}, pack_r};

        // Pack lane writes and lane index; the pack register clears whenever a vector leaves
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                pack_r <= {(W*(NUM-1)){1'b0}};
                idx_r  <= {IDX_W{1'b0}};
            end else if (load_s) begin
                pack_r <= {(W*(NUM-1)){1'b0}};
                idx_r  <= {IDX_W{1'b0}};
            end else if (accept_s) begin
                for (int k = 0; k < NUM - 1; k++) begin
                    if (idx_r == IDX_W'(k)) begin
                        pack_r[k*W +: W] <= in_data;
                    end
                end
                idx_r <= idx_r + IDX_W'(1);
            end
        end
    end else begin : g_direct
        assign pack_ext_s = {W{1'b0}};

        // Single-lane vectors: every element goes straight to the output register
        always_ff @(posedge clk) begin
            idx_r <= {IDX_W{1'b0}};
        end
    end

    // Output register, valid flag and handoff counter; a load wins over a plain drain
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_data  <= {(W*NUM){1'b0}};
            out_valid <= 1'b0;
            vec_count <= 16'd0;
        end else begin
            if (load_s) begin
                out_data  <= next_vec_s;
                out_valid <= 1'b1;
            end else if (handoff_s) begin
                out_valid <= 1'b0;
            end
            if (handoff_s) begin
                vec_count <= vec_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_adder_tree_feeder.sv
// Scoreboard bench for adder_tree_feeder: directed scenarios plus randomized streaming
// with random downstream back-pressure; a monitor pops expected vectors on each handoff.
module tb_adder_tree_feeder;

    localparam int W = 16;
    localparam int N = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [W-1:0]     in_data;
    logic             in_valid;
    logic             in_ready;
    logic [W*N-1:0]   out_data;
    logic             out_valid;
    logic             out_ready;
    logic [15:0]      vec_count;
`ifdef ADDER_TREE_FEEDER_FLUSH_EN
    logic             in_last;
`endif

    always #5 clk = ~clk;

    adder_tree_feeder #(.INPUT_DATA_WIDTH(W), .NUM(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
`ifdef ADDER_TREE_FEEDER_FLUSH_EN
        .in_last   (in_last),
`endif
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .vec_count (vec_count)
    );

    int             n_checks = 0;
    int             n_pass   = 0;
    logic [W*N-1:0] expq[$];
    logic [W-1:0]   partial[$];
    int             hcount   = 0;
    bit             rnd_or   = 1'b0;
    int             st;
    int             stall_sum;
    bit             hold     = 1'b0;
    logic [W*N-1:0] held;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%h expected=%h", name, act, exp);
    endtask

    // Reference model: collect accepted elements; a vector is due after N of them or a last flag
    task automatic model_accept(input logic [W-1:0] d, input bit last);
        logic [W*N-1:0] v;
        partial.push_back(d);
        if (partial.size() == N || last) begin
            v = '0;
            foreach (partial[i]) v[i*W +: W] = partial[i];
            expq.push_back(v);
            partial.delete();
        end
    endtask

    task automatic tick_or();
        if (rnd_or) out_ready = 1'($urandom_range(0, 1));
    endtask

    // Called at a negedge; offers one element and returns at the negedge after it is taken
    task automatic send(input logic [W-1:0] d, input bit last, output int stalls);
        int budget;
        stalls   = 0;
        in_data  = d;
        in_valid = 1'b1;
`ifdef ADDER_TREE_FEEDER_FLUSH_EN
        in_last  = last;
`endif
        tick_or();
        for (budget = 0; budget < 1000; budget++) begin
            #1;
            if (in_ready) break;
            stalls++;
            @(negedge clk);
            tick_or();
        end
        if (budget == 1000) begin
            n_checks++;
            $display("FAIL send_timeout: element %h never accepted", d);
        end else begin
            model_accept(d, last);
            @(negedge clk);
        end
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            tick_or();
            @(negedge clk);
        end
    endtask

    // Monitor: compares every handoff against the scoreboard and checks hold stability
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                hold = 1'b0;
            end else begin
                if (hold) begin
                    chk("hold_valid", 64'(out_valid), 64'd1);
                    chk("hold_data", 64'(out_data), 64'(held));
                end
                if (out_valid && out_ready) begin
                    chk("vec_count", 64'(vec_count), 64'(16'(hcount)));
                    if (expq.size() == 0) begin
                        n_checks++;
                        $display("FAIL unexpected_vector: actual=%h expected=none", out_data);
                    end else begin
                        chk("vector", 64'(out_data), 64'(expq.pop_front()));
                    end
                    hcount++;
                end
                hold = out_valid && !out_ready;
                held = out_data;
            end
        end
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
`ifdef ADDER_TREE_FEEDER_FLUSH_EN
        in_last   = 1'b0;
`endif
        repeat (2) @(negedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_vec_count", 64'(vec_count), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;

        // Basic 4-element vector, visible the cycle after the last element
        for (int i = 1; i <= 4; i++) send(W'(i), 1'b0, st);
        in_valid = 1'b0;
        chk("t1_valid", 64'(out_valid), 64'd1);
        chk("t1_data", 64'(out_data), 64'h0004_0003_0002_0001);
        @(negedge clk);
        chk("t1_vec_count", 64'(vec_count), 64'd1);

        // Continuous 8-element stream, no stalls, back-to-back vectors
        stall_sum = 0;
        for (int i = 1; i <= 8; i++) begin
            send(W'(i), 1'b0, st);
            stall_sum += st;
            if (i == 4) begin
                chk("t2_vecA", 64'(out_data), 64'h0004_0003_0002_0001);
                chk("t2_validA", 64'(out_valid), 64'd1);
            end
        end
        in_valid = 1'b0;
        chk("t2_vecB", 64'(out_data), 64'h0008_0007_0006_0005);
        chk("t2_stalls", 64'(stall_sum), 64'd0);
        idle(2);

        // Back-pressure: final lane stalls while vector A is held
        out_ready = 1'b0;
        for (int i = 1; i <= 7; i++) send(W'(i), 1'b0, st);
        in_data = W'(8);
        #1;
        chk("t3_stall_ready", 64'(in_ready), 64'd0);
        chk("t3_held_A", 64'(out_data), 64'h0004_0003_0002_0001);
        @(negedge clk);
        #1;
        chk("t3_stall_ready2", 64'(in_ready), 64'd0);
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        chk("t3_release_ready", 64'(in_ready), 64'd1);
        model_accept(W'(8), 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        chk("t3_vecB_valid", 64'(out_valid), 64'd1);
        chk("t3_vecB", 64'(out_data), 64'h0008_0007_0006_0005);
        idle(2);

        // Signed extremes copied bit-exact
        send(16'hFFFF, 1'b0, st);
        send(16'h8000, 1'b0, st);
        send(16'h7FFF, 1'b0, st);
        send(16'h0000, 1'b0, st);
        in_valid = 1'b0;
        chk("t4_signed", 64'(out_data), 64'h0000_7FFF_8000_FFFF);
        idle(2);

        // Reset mid-vector discards partial lanes
        send(W'(100), 1'b0, st);
        send(W'(101), 1'b0, st);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        partial.delete();
        expq.delete();
        hcount   = 0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 9; i <= 12; i++) send(W'(i), 1'b0, st);
        in_valid = 1'b0;
        chk("t5_vec", 64'(out_data), 64'h000C_000B_000A_0009);
        @(negedge clk);
        chk("t5_vec_count", 64'(vec_count), 64'd1);
        idle(2);

`ifdef ADDER_TREE_FEEDER_FLUSH_EN
        // Early flush zero-fills upper lanes; the next vector restarts at lane 0
        send(W'(5), 1'b0, st);
        send(W'(6), 1'b1, st);
        in_valid = 1'b0;
        chk("t6_flush", 64'(out_data), 64'h0000_0000_0006_0005);
        for (int i = 7; i <= 10; i++) send(W'(i), 1'b0, st);
        in_valid = 1'b0;
        chk("t6_after", 64'(out_data), 64'h000A_0009_0008_0007);
        idle(2);
`endif

        // Randomized data, gaps and downstream back-pressure
        rnd_or = 1'b1;
        for (int i = 0; i < 400; i++) begin
`ifdef ADDER_TREE_FEEDER_FLUSH_EN
            send(W'($urandom), ($urandom_range(0, 7) == 0), st);
`else
            send(W'($urandom), 1'b0, st);
`endif
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        rnd_or    = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        idle(6);
        chk("drain_empty", 64'(expq.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
